// File: rtl/approx_mult_sched_pkg.sv
// Shared constants, FSM state encoding and helpers for the approximate
// multiplier scheduler.
package approx_mult_sched_pkg;

    localparam int DW      = 16;
    localparam int PW      = 32;
    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 8;
    localparam int CNT_W   = 3;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_RESP  = 2'd3;

    // Index width that stays legal for a single requester.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/approx_mult_sched_rr_arbiter.sv
// Round-robin arbiter: the search starts at i_ptr and wraps, returning a
// one-hot grant and the granted index.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    int w_j;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_j   = 0;
        for (int k = 0; k < N; k++) begin
            w_j = (int'(i_ptr) + k) % N;
            if (!o_any && i_req[w_j]) begin
                o_any      = 1'b1;
                o_gnt[w_j] = 1'b1;
                o_idx      = w_j[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/approx_mult_sched.sv
// Schedules NUM_REQ requesters onto one clock-gated approximate multiplier,
// one operation at a time, and counts the cycles the multiplier is enabled.
//
//   state | meaning
//   IDLE  | arbitrate; req_ready to the round-robin winner
//   ISSUE | mult_en=1 for one cycle with the latched operands
//   WAIT  | MULT_LAT cycles for mult_y; capture on the last edge
//   RESP  | hold rsp_valid/rsp_y/rsp_id until rsp_ready
module approx_mult_sched
    import approx_mult_sched_pkg::*;
#(
    parameter int  NUM_REQ  = 4,
    parameter int  MULT_LAT = 1,
    localparam int IW       = idx_w(NUM_REQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*DW-1:0] req_a,
    input  logic [NUM_REQ*DW-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IW-1:0]         rsp_id,
    output logic [PW-1:0]         rsp_y,
    output logic                  mult_en,
    output logic [DW-1:0]         mult_a,
    output logic [DW-1:0]         mult_b,
    input  logic [PW-1:0]         mult_y,
    input  logic                  stat_clr,
    output logic [31:0]           busy_cycles
);

    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(MULT_LAT - 1);

    state_t             r_state;
    logic [IW-1:0]      r_ptr;
    logic [IW-1:0]      r_id;
    logic [DW-1:0]      r_a;
    logic [DW-1:0]      r_b;
    logic [PW-1:0]      r_y;
    logic [CNT_W-1:0]   r_cnt;
    logic [31:0]        r_busy;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic               w_mult_en;

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_arb (
        .i_req (req_valid),
        .i_ptr (r_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // rst_n gating keeps req_ready low for the whole reset window.
    assign req_ready   = (r_state == ST_IDLE && rst_n) ? w_gnt : '0;
    assign w_mult_en   = (r_state == ST_ISSUE);
    assign mult_en     = w_mult_en;
    assign mult_a      = r_a;
    assign mult_b      = r_b;
    assign rsp_valid   = (r_state == ST_RESP);
    assign rsp_id      = r_id;
    assign rsp_y       = r_y;
    assign busy_cycles = r_busy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_y     <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_a     <= req_a[w_idx*DW +: DW];
                        r_b     <= req_b[w_idx*DW +: DW];
                        r_id    <= w_idx;
                        r_ptr   <= (w_idx == IW'(NUM_REQ - 1)) ? '0 : w_idx + IW'(1);
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt   <= WAIT_LOAD;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_y     <= mult_y;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Clear takes precedence over a coincident increment; counter saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else if (stat_clr) begin
            r_busy <= '0;
        end else if (w_mult_en && !(&r_busy)) begin
            r_busy <= r_busy + 32'd1;
        end
    end

endmodule

// File: tb/tb_approx_mult_sched.sv
// Directed bench: one scheduler with MULT_LAT=1 and one with MULT_LAT=3,
// each driving a behavioural pipelined approximate multiplier.
module tb_approx_mult_sched;
    import approx_mult_sched_pkg::*;

    localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  req_valid, req_ready;
    logic [63:0] req_a, req_b;
    logic        rsp_valid, rsp_ready;
    logic [1:0]  rsp_id;
    logic [31:0] rsp_y;
    logic        mult_en;
    logic [15:0] mult_a, mult_b;
    logic [31:0] mult_y;
    logic        stat_clr;
    logic [31:0] busy_cycles;

    logic [3:0]  req_valid3, req_ready3;
    logic [63:0] req_a3, req_b3;
    logic        rsp_valid3, rsp_ready3;
    logic [1:0]  rsp_id3;
    logic [31:0] rsp_y3;
    logic        mult_en3;
    logic [15:0] mult_a3, mult_b3;
    logic [31:0] mult_y3;
    logic        stat_clr3;
    logic [31:0] busy_cycles3;

    approx_mult_sched #(.NUM_REQ(4), .MULT_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .mult_en(mult_en), .mult_a(mult_a),
        .mult_b(mult_b), .mult_y(mult_y), .stat_clr(stat_clr), .busy_cycles(busy_cycles)
    );

    approx_mult_sched #(.NUM_REQ(4), .MULT_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_a(req_a3), .req_b(req_b3), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_id(rsp_id3), .rsp_y(rsp_y3), .mult_en(mult_en3), .mult_a(mult_a3),
        .mult_b(mult_b3), .mult_y(mult_y3), .stat_clr(stat_clr3), .busy_cycles(busy_cycles3)
    );

    // Approximate product: exact product with the low nibble truncated.
    function automatic logic [31:0] approx(input logic [15:0] a, input logic [15:0] b);
        return ({16'd0, a} * {16'd0, b}) & 32'hFFFF_FFF0;
    endfunction

    // Multiplier models: operands sampled on the edge that ends the enable cycle.
    always @(posedge clk) mult_y <= mult_en ? approx(mult_a, mult_b) : JUNK;

    logic [31:0] p0, p1;
    always @(posedge clk) begin
        p0      <= mult_en3 ? approx(mult_a3, mult_b3) : JUNK;
        p1      <= p0;
        mult_y3 <= p1;
    end

    int cyc = 0;
    int en_cnt = 0;
    int en_cnt3 = 0;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mult_en)  en_cnt  <= en_cnt + 1;
        if (mult_en3) en_cnt3 <= en_cnt3 + 1;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_grant();
        int n;
        n = 0;
        #1;
        while (req_ready == 4'b0 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic wait_rsp();
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            step();
            n++;
        end
        chk("rsp_valid_seen", 32'(rsp_valid), 32'd1);
    endtask

    task automatic run_op(input int idx, input logic [15:0] a, input logic [15:0] b,
                          input logic [31:0] exp_y);
        req_a[idx*16 +: 16] = a;
        req_b[idx*16 +: 16] = b;
        req_valid = 4'(1 << idx);
        wait_grant();
        chk("op_grant", 32'(req_ready), 32'(1 << idx));
        step();
        req_valid = 4'b0;
        wait_rsp();
        chk("op_id", 32'(rsp_id), 32'(idx));
        chk("op_y", rsp_y, exp_y);
        step();
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        int          id;
        logic [31:0] y;
    } vec_t;

    vec_t cont[5];

    initial begin
        int last, e0, t0, n;

        cont[0] = '{16'd100,  16'd25, 0, 32'd2496};
        cont[1] = '{16'd256,  16'd16, 1, 32'd4096};
        cont[2] = '{16'd1024, 16'd8,  2, 32'd8192};
        cont[3] = '{16'd15,   16'd15, 3, 32'd224};
        cont[4] = '{16'd100,  16'd25, 0, 32'd2496};

        req_valid = 4'hF; req_a = '0; req_b = '0; rsp_ready = 1'b1; stat_clr = 1'b0;
        req_valid3 = 4'h0; req_a3 = '0; req_b3 = '0; rsp_ready3 = 1'b1; stat_clr3 = 1'b0;

        // Reset state, with requests pending.
        step(); step();
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_mult_en", 32'(mult_en), 32'd0);
        chk("rst_mult_ab", {mult_a, mult_b}, 32'd0);
        chk("rst_rsp", {31'(rsp_y), rsp_valid}, 32'd0);
        chk("rst_rsp_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", busy_cycles, 32'd0);
        req_valid = 4'h0;
        rst_n = 1'b1;
        step();

        // Single request, cycle by cycle.
        e0 = en_cnt;
        req_a[15:0] = 16'd20; req_b[15:0] = 16'd10; req_valid = 4'b0001;
        #1;
        chk("single_grant", 32'(req_ready), 32'd1);
        step();
        chk("single_issue_en", 32'(mult_en), 32'd1);
        chk("single_issue_ab", {mult_a, mult_b}, {16'd20, 16'd10});
        chk("single_issue_ready", 32'(req_ready), 32'd0);
        req_valid = 4'b0;
        step();
        chk("single_wait_en", 32'(mult_en), 32'd0);
        chk("single_wait_ab", {mult_a, mult_b}, {16'd20, 16'd10});
        chk("single_wait_valid", 32'(rsp_valid), 32'd0);
        step();
        chk("single_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("single_rsp_id", 32'(rsp_id), 32'd0);
        chk("single_rsp_y", rsp_y, 32'd192);
        step();
        chk("single_back_idle", 32'(rsp_valid), 32'd0);
        chk("single_en_cycles", 32'(en_cnt - e0), 32'd1);

        rst_n = 1'b0; step(); rst_n = 1'b1; step();

        // Contention: all four valid, rsp_ready held high.
        req_a = {16'd15, 16'd1024, 16'd256, 16'd100};
        req_b = {16'd15, 16'd8,    16'd16,  16'd25};
        req_valid = 4'hF;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            wait_grant();
            chk("cont_grant", 32'(req_ready), 32'(1 << cont[g].id));
            if (g > 0) chk("cont_gap", 32'(cyc - last), 32'd4);
            last = cyc;
            step();
            if (g == 4) req_valid = 4'b0;
            wait_rsp();
            chk("cont_id", 32'(rsp_id), 32'(cont[g].id));
            chk("cont_y", rsp_y, cont[g].y);
            step();
        end

        // Backpressure: req2 held valid, response stalled for 10 cycles.
        rsp_ready = 1'b0;
        req_a[47:32] = 16'd7; req_b[47:32] = 16'd9; req_valid = 4'b0100;
        wait_grant();
        chk("bp_grant", 32'(req_ready), 32'b0100);
        step();
        wait_rsp();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", 32'(rsp_valid), 32'd1);
            chk("bp_y", rsp_y, 32'd48);
            chk("bp_id", 32'(rsp_id), 32'd2);
            chk("bp_en", 32'(mult_en), 32'd0);
            chk("bp_ready", 32'(req_ready), 32'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", 32'(rsp_valid), 32'd0);
        chk("bp_release_grant", 32'(req_ready), 32'b0100);
        req_valid = 4'b0;
        step();

        // Statistics and gating.
        stat_clr = 1'b1; step(); stat_clr = 1'b0;
        chk("stat_clr_pulse", busy_cycles, 32'd0);
        for (int i = 0; i < 5; i++) run_op(1, 16'd300, 16'd7, 32'd2096);
        req_a = '1; req_b = '1; req_valid = 4'b0;
        e0 = en_cnt;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (mult_en) n++;
        end
        chk("idle_en_samples", 32'(n), 32'd0);
        chk("idle_en_edges", 32'(en_cnt - e0), 32'd0);
        chk("busy_five", busy_cycles, 32'd5);

        // stat_clr coinciding with an increment.
        req_a[31:16] = 16'd3; req_b[31:16] = 16'd32; req_valid = 4'b0010;
        wait_grant();
        step();
        req_valid = 4'b0;
        chk("clr_issue_en", 32'(mult_en), 32'd1);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        chk("clr_wins", busy_cycles, 32'd0);
        wait_rsp();
        chk("clr_op_y", rsp_y, 32'd96);
        step();

        // Reset during WAIT.
        req_a[63:48] = 16'd9; req_b[63:48] = 16'd9; req_valid = 4'b1000;
        wait_grant();
        step();
        req_valid = 4'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("rstw_en", 32'(mult_en), 32'd0);
        chk("rstw_ab", {mult_a, mult_b}, 32'd0);
        chk("rstw_y", rsp_y, 32'd0);
        chk("rstw_id_valid", {29'd0, rsp_id, rsp_valid}, 32'd0);
        chk("rstw_busy", busy_cycles, 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Reset during ISSUE must drop mult_en without waiting for an edge.
        req_a[15:0] = 16'd2; req_b[15:0] = 16'd8; req_valid = 4'b0001;
        wait_grant();
        step();
        req_valid = 4'b0;
        chk("rsti_en_before", 32'(mult_en), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rsti_en_async", 32'(mult_en), 32'd0);
        step();
        rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (rsp_valid) n++;
        end
        chk("rst_discard", 32'(n), 32'd0);
        run_op(2, 16'd11, 16'd13, 32'd128);

        // MULT_LAT=3 instance.
        req_a3[31:16] = 16'd300; req_b3[31:16] = 16'd7; req_valid3 = 4'b0010;
        #1;
        n = 0;
        while (req_ready3 == 4'b0 && n < 20) begin step(); n++; end
        chk("lat3_grant", 32'(req_ready3), 32'b0010);
        t0 = cyc;
        e0 = en_cnt3;
        step();
        req_valid3 = 4'b0;
        n = 0;
        while (!rsp_valid3 && n < 20) begin step(); n++; end
        chk("lat3_latency", 32'(cyc - t0), 32'd5);
        chk("lat3_id", 32'(rsp_id3), 32'd1);
        chk("lat3_y", rsp_y3, 32'd2096);
        chk("lat3_en_cycles", 32'(en_cnt3 - e0), 32'd1);
        chk("lat3_busy", busy_cycles3, 32'd1);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1);
    end

endmodule

// File: doc/approx_mult_sched.md
APPROX_MULT_SCHED -- requirements
Module: approx_mult_sched

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one clock-gated approximate 16-bit multiplier.
REQ-002 SHALL have parameter MULT_LAT, default 1: cycles from the mult_en-high edge to a valid mult_y; legal range 1..8.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state is rising-edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ bits: per-requester operation request.
REQ-006 SHALL have port req_ready, output, NUM_REQ bits: per-requester accept, at most one bit high.
REQ-007 SHALL have port req_a, input, NUM_REQ*16 bits: packed A operands, requester i at bits [16i+15:16i].
REQ-008 SHALL have port req_b, input, NUM_REQ*16 bits: packed B operands, same packing as req_a.
REQ-009 SHALL have port rsp_valid, output, 1 bit: result available.
REQ-010 SHALL have port rsp_ready, input, 1 bit: result consumed.
REQ-011 SHALL have port rsp_id, output, clog2(NUM_REQ) bits: index of the requester that owns the result.
REQ-012 SHALL have port rsp_y, output, 32 bits: captured product.
REQ-013 SHALL have ports mult_en (output, 1), mult_a (output, 16), mult_b (output, 16) and mult_y (input, 32): connection to the shared multiplier's en, A, B and Y pins.
REQ-014 SHALL have port stat_clr, input, 1 bit: synchronous clear of busy_cycles.
REQ-015 SHALL have port busy_cycles, output, 32 bits: count of cycles with mult_en high.

Function
REQ-016 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-017 In IDLE with any req_valid high, the FSM SHALL assert req_ready only for the round-robin winner, in the same cycle (combinational).
REQ-018 On that handshake edge, the FSM SHALL latch the winner's operands and index and move to ISSUE.
REQ-019 Round-robin priority SHALL start at the index after the last grant and wrap from NUM_REQ-1 to 0; after reset, index 0 has top priority.
REQ-020 ISSUE SHALL last exactly one cycle, with mult_en=1 and mult_a/mult_b driving the latched operands; the FSM then moves to WAIT.
REQ-021 WAIT SHALL last MULT_LAT cycles with mult_en=0; on its last edge the FSM SHALL capture mult_y into rsp_y and move to RESP.
REQ-022 mult_a and mult_b SHALL hold the latched operands through ISSUE and WAIT; mult_en SHALL be 0 in every state except ISSUE (clock gate closed when idle).
REQ-023 In RESP, rsp_valid=1 and rsp_y/rsp_id SHALL stay stable until rsp_ready; on the handshake edge the FSM SHALL return to IDLE.
REQ-024 Latency from the req handshake edge to rsp_valid high SHALL be 2+MULT_LAT cycles.
REQ-025 Throughput SHALL be one operation per 3+MULT_LAT cycles when rsp_ready is held high.
REQ-026 req_ready SHALL be 0 in ISSUE, WAIT and RESP.
REQ-027 A req_valid deasserted before the grant SHALL NOT be granted and SHALL NOT advance the round-robin pointer.
REQ-028 busy_cycles SHALL increment on each cycle with mult_en=1 and saturate at 0xFFFF_FFFF.
REQ-029 When stat_clr coincides with an increment, stat_clr SHALL win and the result SHALL be 0.

Reset
REQ-030 While rst_n=0: state IDLE, req_ready=0, mult_en=0, mult_a=mult_b=0, rsp_valid=0, rsp_y=0, rsp_id=0, busy_cycles=0, round-robin pointer at index 0.
REQ-031 Reset asserted mid-operation SHALL abort the operation, force mult_en low immediately (asynchronously), and discard the in-flight result.
REQ-032 After rst_n deasserts, the first grant SHALL occur no earlier than the first rising edge.

Structure
REQ-033 Shared package approx_mult_sched_pkg SHALL hold the DW=16 and PW=32 constants, the FSM state typedef and the MULT_LAT range limits.
REQ-034 Round-robin selection SHALL be a sub-module named rr_arbiter, taking a request vector and a pointer and returning a one-hot grant plus an index.

Verification
REQ-035 Single request: req0 valid, A=20, B=10 -> mult_en high for exactly 1 cycle with mult_a=20, mult_b=10; rsp_valid 3 cycles after the handshake (MULT_LAT=1); rsp_id=0; rsp_y equals mult_y at capture.
REQ-036 Contention: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0, one grant every 4 cycles, with each operand set (100x25, 256x16, 1024x8, 15x15) mapping to the correct rsp_id.
REQ-037 Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_y and rsp_id stable, mult_en=0, req_ready=0 and no new grant; release -> IDLE on the next cycle.
REQ-038 Gating and statistics: 5 ops, then 20 idle cycles with req_a=req_b=0xFFFF and req_valid=0 -> mult_en never high while idle; busy_cycles=5; stat_clr pulse -> 0.
REQ-039 Reset mid-op: rst_n low during WAIT -> all outputs zero at once; after release, a new request to req2 completes normally with rsp_id=2.
REQ-040 MULT_LAT=3 build: latency from handshake to rsp_valid = 5 cycles; rsp_y matches mult_y sampled 3 cycles after the mult_en edge.
